// File: rtl/spi_burst_pkg.sv
// Shared constants for the SPI burst engine: slave register offsets, SPI
// controller register offsets, STATUS bit layout and the master FSM states.
package spi_burst_pkg;

    // CPU-facing register offsets
    localparam logic [23:0] SLV_DATA   = 24'd0;
    localparam logic [23:0] SLV_COUNT  = 24'd1;
    localparam logic [23:0] SLV_STATUS = 24'd2;
    localparam logic [23:0] SLV_ABORT  = 24'd3;

    // SPI controller register offsets driven by the master port
    localparam logic [23:0] SPI_TX   = 24'd0;
    localparam logic [23:0] SPI_RX   = 24'd1;
    localparam logic [23:0] SPI_STAT = 24'd2;

    // STATUS read bit positions (levels occupy [15:11] and [10:6])
    localparam int ST_BUSY      = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_DONE      = 3;
    localparam int ST_UNDERFLOW = 4;
    localparam int ST_IRQ_EN    = 5;

    // STATUS write bit positions
    localparam int WR_CLR_DONE = 1;
    localparam int WR_CLR_UFL  = 2;
    localparam int WR_IRQ_EN   = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_WR_TX,
        S_POLL,
        S_RD_RX
    } state_e;

    function automatic logic [15:0] pack_status(
        input logic [4:0] rx_lvl,
        input logic [4:0] tx_lvl,
        input logic       irq_en,
        input logic       underflow,
        input logic       done,
        input logic       rx_empty,
        input logic       tx_full,
        input logic       busy
    );
        logic [15:0] s;
        s               = {rx_lvl, tx_lvl, 6'b000000};
        s[ST_IRQ_EN]    = irq_en;
        s[ST_UNDERFLOW] = underflow;
        s[ST_DONE]      = done;
        s[ST_RX_EMPTY]  = rx_empty;
        s[ST_TX_FULL]   = tx_full;
        s[ST_BUSY]      = busy;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Push into a full FIFO and pop from an empty FIFO are
// ignored; push and pop in the same cycle both take effect.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + {{(LW-1){1'b0}}, do_push} - {{(LW-1){1'b0}}, do_pop};
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spi_burst_engine.sv
// Wishbone byte-stream front end: CPU loads TX bytes and a count, the master
// FSM walks the SPI controller register map once per byte and collects RX.
//
// state        | meaning
// S_IDLE       | no burst; waiting for a non-zero COUNT write
// S_WAIT_SPACE | holds off until the RX FIFO has room for the next byte
// S_WR_TX      | writes TX head (or fill byte) to SPI TX register
// S_POLL       | reads SPI status until its busy bit clears
// S_RD_RX      | reads SPI RX register, pushes byte, decrements count
module spi_burst_engine
    import spi_burst_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] wb_adr,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [15:0] wb_i_dat,
    output logic [15:0] wb_o_dat,
    output logic        wb_ack,
    output logic [23:0] m_wb_adr,
    output logic        m_wb_cyc,
    output logic        m_wb_stb,
    output logic        m_wb_we,
    output logic [15:0] m_wb_o_dat,
    input  logic [15:0] m_wb_i_dat,
    input  logic        m_wb_ack,
    output logic        o_irq
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    state_e        state_q, state_d;
    logic          gap_q, gap_d;
    logic          abort_q, abort_d;
    logic [15:0]   count_q, count_d;
    logic          done_q, done_d;
    logic          ufl_q, ufl_d;
    logic          irq_en_q, irq_en_d;

    logic          slv_wr, slv_rd;
    logic          cpu_tx_push, cpu_rx_pop, count_wr, status_wr, abort_wr;
    logic          tx_pop_m, rx_push_m, done_set, ufl_set;
    logic          m_cyc;
    logic [23:0]   m_adr;
    logic [7:0]    tx_head, rx_head, tx_byte;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [LW-1:0] tx_level, rx_level;
    logic          busy;
    logic          unused_m_hi;

    assign unused_m_hi = ^m_wb_i_dat[15:8];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(i_clk), .rst_i(i_rst),
        .push_i(cpu_tx_push), .data_i(wb_i_dat[7:0]),
        .pop_i(tx_pop_m), .data_o(tx_head),
        .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(i_clk), .rst_i(i_rst),
        .push_i(rx_push_m), .data_i(m_wb_i_dat[7:0]),
        .pop_i(cpu_rx_pop), .data_o(rx_head),
        .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
    );

    assign wb_ack      = wb_cyc & wb_stb;
    assign slv_wr      = wb_ack & wb_we;
    assign slv_rd      = wb_ack & ~wb_we;
    assign cpu_tx_push = slv_wr & (wb_adr == SLV_DATA);
    assign cpu_rx_pop  = slv_rd & (wb_adr == SLV_DATA);
    assign count_wr    = slv_wr & (wb_adr == SLV_COUNT);
    assign status_wr   = slv_wr & (wb_adr == SLV_STATUS);
    assign abort_wr    = slv_wr & (wb_adr == SLV_ABORT);
    assign busy        = (state_q != S_IDLE);
    assign tx_byte     = tx_empty ? FILL_BYTE : tx_head;

    // Slave read mux; a DATA read of an empty RX FIFO returns zero.
    always_comb begin
        wb_o_dat = '0;
        case (wb_adr)
            SLV_DATA:   if (!rx_empty) wb_o_dat = {8'h00, rx_head};
            SLV_COUNT:  wb_o_dat = count_q;
            SLV_STATUS: wb_o_dat = pack_status(5'(rx_level), 5'(tx_level), irq_en_q, ufl_q,
                                               done_q, rx_empty, tx_full, busy);
            default:    wb_o_dat = '0;
        endcase
    end

    // State and control registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            gap_q    <= 1'b0;
            abort_q  <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
            ufl_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            abort_q  <= abort_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ufl_q    <= ufl_d;
            irq_en_q <= irq_en_d;
        end
    end

    // Master FSM: one bus access per state, one idle clock after every ack.
    always_comb begin
        state_d   = state_q;
        gap_d     = 1'b0;
        abort_d   = abort_q;
        count_d   = count_q;
        done_set  = 1'b0;
        ufl_set   = 1'b0;
        tx_pop_m  = 1'b0;
        rx_push_m = 1'b0;
        m_cyc     = 1'b0;
        m_adr     = SPI_TX;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (count_wr && (wb_i_dat != 16'd0)) begin
                    count_d = wb_i_dat;
                    state_d = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (abort_wr) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (!rx_full) begin
                    state_d = S_WR_TX;
                end
            end
            S_WR_TX: begin
                m_cyc = ~gap_q;
                m_adr = SPI_TX;
                if (m_cyc && m_wb_ack) begin
                    gap_d = 1'b1;
                    state_d = S_POLL;
                    if (tx_empty) ufl_set = 1'b1;
                    else          tx_pop_m = 1'b1;
                end
            end
            S_POLL: begin
                m_cyc = ~gap_q;
                m_adr = SPI_STAT;
                if (m_cyc && m_wb_ack) begin
                    gap_d = 1'b1;
                    if (!m_wb_i_dat[0]) state_d = (abort_q || abort_wr) ? S_IDLE : S_RD_RX;
                end
            end
            S_RD_RX: begin
                m_cyc = ~gap_q;
                m_adr = SPI_RX;
                if (m_cyc && m_wb_ack) begin
                    gap_d     = 1'b1;
                    rx_push_m = 1'b1;
                    if (count_q != 16'd0) count_d = count_q - 16'd1;
                    if (abort_q || abort_wr) begin
                        state_d = S_IDLE;
                    end else if (count_q == 16'd1) begin
                        state_d  = S_IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_d = S_WAIT_SPACE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // An abort mid-access lets the SPI byte finish but drops the count now.
        if (abort_wr && (state_q inside {S_WR_TX, S_POLL, S_RD_RX})) begin
            abort_d = 1'b1;
            count_d = '0;
        end
    end

    // Sticky flags; a set in the same cycle as a clear wins.
    always_comb begin
        done_d   = (done_q & ~(status_wr & wb_i_dat[WR_CLR_DONE])) | done_set;
        ufl_d    = (ufl_q & ~(status_wr & wb_i_dat[WR_CLR_UFL])) | ufl_set;
        irq_en_d = status_wr ? wb_i_dat[WR_IRQ_EN] : irq_en_q;
    end

    // Reset gates the master cycle combinationally so it drops at once.
    assign m_wb_cyc   = m_cyc & ~i_rst;
    assign m_wb_stb   = m_wb_cyc;
    assign m_wb_we    = m_wb_cyc & (state_q == S_WR_TX);
    assign m_wb_adr   = m_wb_cyc ? m_adr : '0;
    assign m_wb_o_dat = m_wb_we ? {8'h00, tx_byte} : '0;
    assign o_irq      = done_q & irq_en_q;

endmodule
